// File: rtl/formacao_inimigos.sv
// Enemy formation controller: N_COLS x N_ROWS grid that marches, steps down at
// the screen edges, speeds up as enemies die, and reports victory or invasion.
module formacao_inimigos #(
    parameter int unsigned N_COLS       = 5,
    parameter int unsigned N_ROWS       = 1,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned X0           = 40,
    parameter int unsigned Y0           = 32,
    parameter int unsigned ESP_X        = 64,
    parameter int unsigned ESP_Y        = 40,
    parameter int unsigned LARG_INIM    = 32,
    parameter int unsigned ALT_INIM     = 24,
    parameter int unsigned PASSO_X      = 4,
    parameter int unsigned PASSO_Y      = 16,
    parameter int unsigned LARGURA_TELA = 640,
    parameter int unsigned Y_LIMITE     = 440,
    parameter int unsigned TICK_BASE    = 2000000,
    parameter int unsigned TICK_DEC     = 100000,
    parameter int unsigned TICK_MIN     = 200000
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           pausa,
    input  logic                           iniciar,
    input  logic                           acerto_valido,
    input  logic [IDX_W-1:0]               acerto_idx,
    output logic [10*N_COLS*N_ROWS-1:0]    inimigo_x,
    output logic [10*N_COLS*N_ROWS-1:0]    inimigo_y,
    output logic [N_COLS*N_ROWS-1:0]       inimigo_vivo_array,
    output logic                           direcao,
    output logic                           mov_tick,
    output logic                           acerto_ok,
    output logic [IDX_W:0]                 vivos,
    output logic                           vitoria,
    output logic                           invadiu
);

    localparam int unsigned N  = N_COLS * N_ROWS;
    localparam int unsigned CW = IDX_W + 1;

    typedef enum logic [1:0] {OCIOSO, MARCHA, FIM} estado_t;

    estado_t         estado, estado_n;
    logic [9:0]      x_org, x_n, y_org, y_n;
    logic [N-1:0]    vivo, vivo_n, vivo_hit;
    logic            dir_r, dir_n;
    logic [31:0]     div_r, div_n;
    logic [CW-1:0]   mortos, mortos_n;
    logic            mov_tick_r, mov_tick_n;
    logic            acerto_ok_r, acerto_ok_n;
    logic            vitoria_r, vitoria_n;
    logic            invadiu_r, invadiu_n;
    logic            hit_ok, mover;
    logic [31:0]     min_c, max_c, max_r;
    logic [31:0]     dec, sub, periodo;

    // Extent of the live formation: outermost live columns and lowest live row
    always_comb begin : p_extents
        logic col_viva;
        logic lin_viva;
        logic achou;
        min_c = '0;
        max_c = '0;
        max_r = '0;
        achou = 1'b0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            col_viva = 1'b0;
            for (int unsigned r = 0; r < N_ROWS; r++) begin
                col_viva = col_viva | vivo[r*N_COLS + c];
            end
            if (col_viva) begin
                if (!achou) begin
                    min_c = c;
                end
                max_c = c;
                achou = 1'b1;
            end
        end
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            lin_viva = 1'b0;
            for (int unsigned c = 0; c < N_COLS; c++) begin
                lin_viva = lin_viva | vivo[r*N_COLS + c];
            end
            if (lin_viva) begin
                max_r = r;
            end
        end
    end

    // Hit decode: only an in-range index pointing at a live enemy counts
    always_comb begin : p_acerto
        hit_ok   = 1'b0;
        vivo_hit = vivo;
        for (int unsigned i = 0; i < N; i++) begin
            if (acerto_valido && (32'(acerto_idx) == i) && vivo[i]) begin
                hit_ok      = 1'b1;
                vivo_hit[i] = 1'b0;
            end
        end
    end

    // Move period shrinks per kill, saturating at the floor
    always_comb begin : p_periodo
        dec     = TICK_DEC * 32'(mortos);
        sub     = (dec >= TICK_BASE) ? 32'd0 : (TICK_BASE - dec);
        periodo = (sub < TICK_MIN) ? TICK_MIN : sub;
    end

    // Next-state and datapath update
    always_comb begin : p_proximo
        estado_n    = estado;
        x_n         = x_org;
        y_n         = y_org;
        vivo_n      = vivo;
        dir_n       = dir_r;
        div_n       = div_r;
        mortos_n    = mortos;
        mov_tick_n  = 1'b0;
        acerto_ok_n = 1'b0;
        vitoria_n   = vitoria_r;
        invadiu_n   = invadiu_r;
        mover       = 1'b0;

        case (estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_n  = MARCHA;
                    x_n       = 10'(X0);
                    y_n       = 10'(Y0);
                    vivo_n    = '1;
                    dir_n     = 1'b1;
                    div_n     = '0;
                    mortos_n  = '0;
                    vitoria_n = 1'b0;
                    invadiu_n = 1'b0;
                end
            end
            MARCHA: begin
                if (!pausa) begin
                    if (div_r + 32'd1 >= periodo) begin
                        div_n = '0;
                        mover = 1'b1;
                    end else begin
                        div_n = div_r + 32'd1;
                    end
                end
                if (mover) begin
                    mov_tick_n = 1'b1;
                    if (dir_r ? (32'(x_org) + max_c*ESP_X + LARG_INIM + PASSO_X > LARGURA_TELA - 1)
                              : (32'(x_org) + min_c*ESP_X < PASSO_X)) begin
                        y_n   = y_org + 10'(PASSO_Y);
                        dir_n = ~dir_r;
                    end else if (dir_r) begin
                        x_n = x_org + 10'(PASSO_X);
                    end else begin
                        x_n = x_org - 10'(PASSO_X);
                    end
                    if (32'(y_n) + max_r*ESP_Y + ALT_INIM >= Y_LIMITE) begin
                        invadiu_n = 1'b1;
                        estado_n  = FIM;
                    end
                end
                if (hit_ok) begin
                    vivo_n      = vivo_hit;
                    mortos_n    = mortos + CW'(1);
                    acerto_ok_n = 1'b1;
                    // Last kill wins over a simultaneous invasion
                    if (vivo_hit == '0) begin
                        vitoria_n = 1'b1;
                        invadiu_n = invadiu_r;
                        estado_n  = FIM;
                    end
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            x_org       <= 10'(X0);
            y_org       <= 10'(Y0);
            vivo        <= '1;
            dir_r       <= 1'b1;
            div_r       <= '0;
            mortos      <= '0;
            mov_tick_r  <= 1'b0;
            acerto_ok_r <= 1'b0;
            vitoria_r   <= 1'b0;
            invadiu_r   <= 1'b0;
        end else begin
            estado      <= estado_n;
            x_org       <= x_n;
            y_org       <= y_n;
            vivo        <= vivo_n;
            dir_r       <= dir_n;
            div_r       <= div_n;
            mortos      <= mortos_n;
            mov_tick_r  <= mov_tick_n;
            acerto_ok_r <= acerto_ok_n;
            vitoria_r   <= vitoria_n;
            invadiu_r   <= invadiu_n;
        end
    end

    // Per-enemy positions are fixed offsets from the formation origin
    for (genvar i = 0; i < N; i++) begin : g_pos
        localparam int unsigned COL = i % N_COLS;
        localparam int unsigned ROW = i / N_COLS;
        assign inimigo_x[10*i +: 10] = x_org + 10'(COL * ESP_X);
        assign inimigo_y[10*i +: 10] = y_org + 10'(ROW * ESP_Y);
    end

    assign inimigo_vivo_array = vivo;
    assign direcao            = dir_r;
    assign mov_tick           = mov_tick_r;
    assign acerto_ok          = acerto_ok_r;
    assign vivos              = CW'(N) - mortos;
    assign vitoria            = vitoria_r;
    assign invadiu            = invadiu_r;

endmodule

// File: tb/tb_formacao_inimigos.sv
// Directed bench for formacao_inimigos on a 3x2 grid with a short tick period.
module tb_formacao_inimigos;

    logic        clk = 1'b0;
    logic        reset;
    logic        pausa;
    logic        iniciar;
    logic        acerto_valido;
    logic [7:0]  acerto_idx;
    logic [59:0] inimigo_x;
    logic [59:0] inimigo_y;
    logic [5:0]  vivo;
    logic        direcao;
    logic        mov_tick;
    logic        acerto_ok;
    logic [8:0]  vivos;
    logic        vitoria;
    logic        invadiu;

    int errors = 0;
    int checks = 0;
    int n;
    int nt;

    always #5 clk = ~clk;

    formacao_inimigos #(
        .N_COLS(3), .N_ROWS(2), .IDX_W(8), .X0(0), .Y0(0),
        .ESP_X(40), .ESP_Y(32), .LARG_INIM(32), .ALT_INIM(24),
        .PASSO_X(8), .PASSO_Y(16), .LARGURA_TELA(128), .Y_LIMITE(200),
        .TICK_BASE(4), .TICK_DEC(1), .TICK_MIN(2)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .pausa(pausa),
        .iniciar(iniciar),
        .acerto_valido(acerto_valido),
        .acerto_idx(acerto_idx),
        .inimigo_x(inimigo_x),
        .inimigo_y(inimigo_y),
        .inimigo_vivo_array(vivo),
        .direcao(direcao),
        .mov_tick(mov_tick),
        .acerto_ok(acerto_ok),
        .vivos(vivos),
        .vitoria(vitoria),
        .invadiu(invadiu)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ex(input int i);
        return inimigo_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] ey(input int i);
        return inimigo_y[10*i +: 10];
    endfunction

    // Ticks until the next move pulse, bounded; returns cycles taken
    task automatic esperar_mov(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!mov_tick && cnt < 40);
    endtask

    task automatic acerto(input int idx);
        acerto_valido = 1'b1;
        acerto_idx    = 8'(idx);
        tick();
        acerto_valido = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; pausa = 1'b0; iniciar = 1'b0;
        acerto_valido = 1'b0; acerto_idx = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x0", 64'(ex(0)), 64'(0));
        check("rst_y0", 64'(ey(0)), 64'(0));
        check("rst_mask", 64'(vivo), 64'(6'b111111));
        check("rst_dir", 64'(direcao), 64'(1));
        check("rst_vivos", 64'(vivos), 64'(6));
        check("rst_flags", 64'({mov_tick, acerto_ok, vitoria, invadiu}), 64'(0));
        reset = 1'b1;
        repeat (6) tick();
        check("idle_x0", 64'(ex(0)), 64'(0));

        // Marching with no hits: period 4
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        esperar_mov(n);
        check("t1_lat", 64'(n), 64'(4));
        check("t1_x8", 64'(ex(0)), 64'(8));
        esperar_mov(n);
        check("t1_per", 64'(n), 64'(4));
        check("t1_edge_y", 64'(ey(0)), 64'(16));
        check("t1_edge_dir", 64'(direcao), 64'(0));
        check("t1_edge_x", 64'(ex(0)), 64'(8));
        esperar_mov(n);
        check("t1_left_x", 64'(ex(0)), 64'(0));
        esperar_mov(n);
        check("t1_edge2_y", 64'(ey(0)), 64'(32));
        check("t1_edge2_dir", 64'(direcao), 64'(1));
        check("t1_e4_x", 64'(ex(4)), 64'(40));
        check("t1_e4_y", 64'(ey(4)), 64'(64));

        // Kill column 2, period drops to the floor, right edge moves in
        acerto(2);
        check("t2_ok1", 64'(acerto_ok), 64'(1));
        acerto(5);
        check("t2_ok2", 64'(acerto_ok), 64'(1));
        check("t2_mask", 64'(vivo), 64'(6'b011011));
        check("t2_vivos", 64'(vivos), 64'(4));
        esperar_mov(n);
        check("t2_first", 64'(n), 64'(1));
        check("t2_x8", 64'(ex(0)), 64'(8));
        for (int k = 0; k < 5; k++) begin
            esperar_mov(n);
            check("t2_per2", 64'(n), 64'(2));
        end
        check("t2_x48", 64'(ex(0)), 64'(48));
        check("t2_y32", 64'(ey(0)), 64'(32));
        esperar_mov(n);
        check("t2_edge_y", 64'(ey(0)), 64'(48));
        check("t2_edge_dir", 64'(direcao), 64'(0));
        check("t2_edge_x", 64'(ex(0)), 64'(48));

        // Dead and out-of-range hits are ignored
        acerto(2);
        check("t3_dead", 64'(acerto_ok), 64'(0));
        acerto(7);
        check("t3_range", 64'(acerto_ok), 64'(0));
        check("t3_mask", 64'(vivo), 64'(6'b011011));
        check("t3_vivos", 64'(vivos), 64'(4));

        // Kill the rest: victory, then everything holds
        acerto(0);
        check("t4_ok0", 64'(acerto_ok), 64'(1));
        acerto(1);
        acerto(3);
        acerto(4);
        check("t4_ok4", 64'(acerto_ok), 64'(1));
        check("t4_vit", 64'(vitoria), 64'(1));
        check("t4_inv", 64'(invadiu), 64'(0));
        check("t4_vivos", 64'(vivos), 64'(0));
        check("t4_mask", 64'(vivo), 64'(0));
        check("t4_x", 64'(ex(0)), 64'(24));
        check("t4_y", 64'(ey(0)), 64'(48));
        nt = 0;
        repeat (10) begin
            tick();
            if (mov_tick) nt++;
        end
        check("t4_fim_ticks", 64'(nt), 64'(0));
        check("t4_fim_x", 64'(ex(0)), 64'(24));
        check("t4_fim_vit", 64'(vitoria), 64'(1));

        // Restart, kill bottom row, march to the invasion line
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        check("t5_mask", 64'(vivo), 64'(6'b111111));
        check("t5_org", 64'({ex(0), ey(0)}), 64'(0));
        check("t5_vit", 64'(vitoria), 64'(0));
        check("t5_vivos", 64'(vivos), 64'(6));
        acerto(3);
        acerto(4);
        acerto(5);
        check("t5_mask_r0", 64'(vivo), 64'(6'b000111));
        n = 0;
        while (!invadiu && n < 400) begin
            tick();
            n++;
        end
        check("t5_inv", 64'(invadiu), 64'(1));
        check("t5_inv_y", 64'(ey(0)), 64'(176));
        check("t5_inv_x", 64'(ex(0)), 64'(8));
        check("t5_inv_dir", 64'(direcao), 64'(0));
        check("t5_inv_vit", 64'(vitoria), 64'(0));
        repeat (8) tick();
        check("t5_hold_y", 64'(ey(0)), 64'(176));

        // Both rows alive: invasion arrives earlier
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        check("t5b_inv_clr", 64'(invadiu), 64'(0));
        n = 0;
        while (!invadiu && n < 400) begin
            tick();
            n++;
        end
        check("t5b_inv", 64'(invadiu), 64'(1));
        check("t5b_y0", 64'(ey(0)), 64'(144));
        check("t5b_y3", 64'(ey(3)), 64'(176));
        check("t5b_x5", 64'(ex(5)), 64'(88));

        // Pause freezes the divider; hits still land
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        tick();
        tick();
        pausa = 1'b1;
        acerto(0);
        check("t6_hit_pausa", 64'(acerto_ok), 64'(1));
        nt = 0;
        repeat (9) begin
            tick();
            if (mov_tick) nt++;
        end
        check("t6_pausa_ticks", 64'(nt), 64'(0));
        check("t6_pausa_x", 64'(ex(0)), 64'(0));
        pausa = 1'b0;
        esperar_mov(n);
        check("t6_resume", 64'(n), 64'(1));
        check("t6_resume_x", 64'(ex(0)), 64'(8));

        // Asynchronous reset mid-game
        tick();
        reset = 1'b0;
        #2;
        check("t6_rst_mask", 64'(vivo), 64'(6'b111111));
        check("t6_rst_org", 64'({ex(0), ey(0)}), 64'(0));
        check("t6_rst_dir", 64'(direcao), 64'(1));
        check("t6_rst_vivos", 64'(vivos), 64'(6));
        check("t6_rst_flags", 64'({mov_tick, acerto_ok, vitoria, invadiu}), 64'(0));
        tick();
        reset = 1'b1;
        nt = 0;
        repeat (8) begin
            tick();
            if (mov_tick) nt++;
        end
        check("t6_idle_ticks", 64'(nt), 64'(0));
        check("t6_idle_x", 64'(ex(0)), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
